// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scans a 4x4 matrix keypad one column at a time and debounces the presses
// and releases it finds. The scan uses a slow tick derived from clk. The
// controller samples the rows once per tick. While a key is being debounced
// or held, the column stays frozen and only the latched row is watched.
//
// Parameters
//   SCAN_DIV   clk cycles per scan tick (column dwell), >= 4
//   DEB_TICKS  consecutive matching tick samples needed to accept a press
//              or a release, >= 2
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-low reset
//   row_in     keypad rows, asynchronous, active-low (pulled up)
//   col_out    column drive, active-low, exactly one bit low
//   key_valid  one-clk pulse on an accepted press
//   key_code   code of the last accepted key, col*4+row
//   key_down   high while the accepted key is held
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SCAN_DIV  = 100000,
    parameter int DEB_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_TICKS);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    localparam logic [1:0] ST_SCAN         = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    logic [3:0]       row_meta_reg;
    logic [3:0]       row_sync_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [1:0]       state_reg,   state_next;
    logic [1:0]       col_reg,     col_next;
    logic [1:0]       row_sel_reg, row_sel_next;
    logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic             key_valid_reg, key_valid_next;
    logic [3:0]       key_code_reg,  key_code_next;
    logic             key_down_reg,  key_down_next;

    logic             tick;
    logic             latched_low;
    logic [DEB_W-1:0] deb_inc;
    logic [1:0]       lowest_row;

    assign tick        = (div_cnt_reg == DIV_LAST);
    assign latched_low = ~row_sync_reg[row_sel_reg];
    // Saturating increment: the counter can never wrap past DEB_TICKS.
    assign deb_inc     = (deb_cnt_reg >= DEB_MAX) ? DEB_MAX : deb_cnt_reg + DEB_ONE;

    // Lowest-index low row wins when several keys share the column.
    always_comb begin
        lowest_row = 2'd0;
        casez (row_sync_reg)
            4'b???0: lowest_row = 2'd0;
            4'b??01: lowest_row = 2'd1;
            4'b?011: lowest_row = 2'd2;
            4'b0111: lowest_row = 2'd3;
            default: lowest_row = 2'd0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_sel_next   = row_sel_reg;
        deb_cnt_next   = deb_cnt_reg;
        key_code_next  = key_code_reg;
        key_down_next  = key_down_reg;
        key_valid_next = 1'b0;

        if (tick) begin
            case (state_reg)
                ST_SCAN: begin
                    if (&row_sync_reg) begin
                        col_next = col_reg + 2'd1;
                    end else begin
                        row_sel_next = lowest_row;
                        deb_cnt_next = DEB_ONE;
                        state_next   = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (latched_low) begin
                        deb_cnt_next = deb_inc;
                        if (deb_inc >= DEB_MAX) begin
                            state_next     = ST_PRESSED;
                            key_valid_next = 1'b1;
                            key_code_next  = {col_reg, row_sel_reg};
                            key_down_next  = 1'b1;
                        end
                    end else begin
                        // Bounce: return to scanning the same column.
                        deb_cnt_next = '0;
                        state_next   = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (!latched_low) begin
                        deb_cnt_next = DEB_ONE;
                        state_next   = ST_RELEASE_WAIT;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!latched_low) begin
                        deb_cnt_next = deb_inc;
                        if (deb_inc >= DEB_MAX) begin
                            deb_cnt_next  = '0;
                            state_next    = ST_SCAN;
                            key_down_next = 1'b0;
                            col_next      = col_reg + 2'd1;
                        end
                    end else begin
                        // Release bounce: still held, no new report.
                        deb_cnt_next = DEB_MAX;
                        state_next   = ST_PRESSED;
                    end
                end
                default: begin
                    state_next = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_meta_reg  <= 4'b1111;
            row_sync_reg  <= 4'b1111;
            div_cnt_reg   <= '0;
            state_reg     <= ST_SCAN;
            col_reg       <= 2'd0;
            row_sel_reg   <= 2'd0;
            deb_cnt_reg   <= '0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'd0;
            key_down_reg  <= 1'b0;
        end else begin
            row_meta_reg  <= row_in;
            row_sync_reg  <= row_meta_reg;
            div_cnt_reg   <= tick ? '0 : div_cnt_reg + 1'b1;
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_sel_reg   <= row_sel_next;
            deb_cnt_reg   <= deb_cnt_next;
            key_valid_reg <= key_valid_next;
            key_code_reg  <= key_code_next;
            key_down_reg  <= key_down_next;
        end
    end

    // One-cold column decode.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_out[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign key_down  = key_down_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DIV(DIV), .DEB_TICKS(DEB)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    int checks = 0;
    int errors = 0;
    int kv_seen = 0;

    // Physical keypad: bit col*4+row set means that key is pressed.
    logic [15:0] pressed = '0;
    bit          glitch  = 0;

    // Reference model: tracks the scanner in terms of "which column is
    // selected", "which key is locked" and run lengths of equal samples.
    logic [3:0] m_s1, m_s2, m_code;
    int         m_cnt, m_col, m_lrow, m_run;
    bit         m_locked, m_acc, m_kv, m_down;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst_v, input logic [3:0] rin);
        logic [3:0] samp;
        bit         tick;
        if (!rst_v) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_cnt = 0; m_col = 0; m_lrow = 0;
            m_locked = 0; m_acc = 0; m_run = 0; m_kv = 0; m_code = 4'h0; m_down = 0;
            return;
        end
        samp  = m_s2;
        tick  = (m_cnt == DIV - 1);
        m_s2  = m_s1;
        m_s1  = rin;
        m_cnt = tick ? 0 : m_cnt + 1;
        m_kv  = 0;
        if (!tick) return;
        if (!m_locked) begin
            if (samp == 4'hF) begin
                m_col = (m_col + 1) % 4;
            end else begin
                m_locked = 1;
                m_acc    = 0;
                m_run    = 1;
                for (int r = 3; r >= 0; r--) if (!samp[r]) m_lrow = r;
            end
        end else if (!m_acc) begin
            if (!samp[m_lrow]) begin
                m_run++;
                if (m_run == DEB) begin
                    m_acc = 1; m_kv = 1; m_down = 1; m_run = 0;
                    m_code = 4'(m_col * 4 + m_lrow);
                end
            end else begin
                m_locked = 0;
            end
        end else begin
            if (samp[m_lrow]) begin
                m_run++;
                if (m_run == DEB) begin
                    m_locked = 0; m_acc = 0; m_down = 0;
                    m_col = (m_col + 1) % 4;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step_cycle();
        logic [3:0] rows;
        logic [3:0] one;
        @(negedge clk);
        rows = 4'hF;
        for (int r = 0; r < 4; r++) if (pressed[m_col * 4 + r]) rows[r] = 1'b0;
        if (glitch) rows[$urandom_range(0, 3)] ^= 1'b1;
        row_in = rows;
        @(posedge clk);
        #1;
        model_step(rst_n, row_in);
        one = 4'b0001;
        check("col_out",   col_out,         ~(one << m_col));
        check("key_valid", {3'b0, key_valid}, {3'b0, m_kv});
        check("key_code",  key_code,        m_code);
        check("key_down",  {3'b0, key_down}, {3'b0, m_down});
        if (key_valid === 1'b1) kv_seen++;
        $display("cyc rst=%b row=%b col=%b kv=%b code=%0d down=%b",
                 rst_n, row_in, col_out, key_valid, key_code, key_down);
    endtask

    initial begin
        rst_n  = 1'b0;
        row_in = 4'hF;
        m_col  = 0;

        // Reset state.
        repeat (3) step_cycle();
        rst_n = 1'b1;

        // Idle rotation.
        repeat (40) step_cycle();
        check("idle_no_valid", 4'(kv_seen), 4'd0);

        // Two keys in column 0 (rows 1 and 3): lowest row wins.
        pressed = 16'h000A;
        repeat (80) step_cycle();
        check("lowest_row_code", key_code, 4'd1);
        pressed = '0;
        repeat (60) step_cycle();

        // Randomised presses, releases and single-bit bounces.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) pressed ^= 16'(1) << $urandom_range(0, 15);
            if ($countones(pressed) > 2) pressed = '0;
            glitch = ($urandom_range(0, 29) == 0);
            step_cycle();
        end
        glitch  = 0;
        pressed = '0;
        repeat (80) step_cycle();

        // Reset mid-press, key still held: re-debounced and reported once.
        pressed = 16'h0040;
        for (int i = 0; i < 500 && !m_acc; i++) step_cycle();
        check("press_reached", {3'b0, key_down}, 4'd1);
        rst_n = 1'b0;
        repeat (3) step_cycle();
        rst_n   = 1'b1;
        kv_seen = 0;
        repeat (200) step_cycle();
        check("reset_repress_count", 4'(kv_seen), 4'd1);
        check("reset_repress_code",  key_code, 4'd6);
        pressed = '0;
        repeat (60) step_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
